// File: rtl/rv64g_l2_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rv64g_l2_dir_ctrl
// Description : L2 coherence directory. Each set/way holds a valid bit, a
//               per-core sharer vector, an owner (valid + id) and a dirty
//               bit. One op is processed at a time as a read-modify-write of
//               the whole set, and the full post-op set image is returned.
//               After reset a sweep zeroes every set before requests are
//               accepted.
// Ports       : clk, rst_n (async, active low)
//               init_busy_o               - post-reset sweep running
//               req_valid_i / req_ready_o - request handshake
//               req_op/set/way/core/dirty - request fields
//               rsp_valid_o / rsp_ready_i - response handshake
//               rsp_hit_o, rsp_err_o      - target hit / illegal request
//               rsp_valid_vec_o, rsp_sharers_o, rsp_owner_valid_o,
//               rsp_owner_id_o, rsp_dirty_o - post-op set image
// Revision    : 1.0 - initial release
// ============================================================================
module rv64g_l2_dir_ctrl #(
    parameter int SETS  = 256,
    parameter int WAYS  = 16,
    parameter int CORES = 4,
    localparam int SET_W = $clog2(SETS),
    localparam int WAY_W = $clog2(WAYS),
    localparam int OID_W = $clog2(CORES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   init_busy_o,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [2:0]             req_op_i,
    input  logic [SET_W-1:0]       req_set_i,
    input  logic [WAY_W-1:0]       req_way_i,
    input  logic [OID_W-1:0]       req_core_i,
    input  logic                   req_dirty_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic                   rsp_hit_o,
    output logic                   rsp_err_o,
    output logic [WAYS-1:0]        rsp_valid_vec_o,
    output logic [WAYS*CORES-1:0]  rsp_sharers_o,
    output logic [WAYS-1:0]        rsp_owner_valid_o,
    output logic [WAYS*OID_W-1:0]  rsp_owner_id_o,
    output logic [WAYS-1:0]        rsp_dirty_o
);

    localparam logic [2:0]       C_OP_LOOKUP = 3'd0;
    localparam logic [2:0]       C_OP_ADD    = 3'd1;
    localparam logic [2:0]       C_OP_REMOVE = 3'd2;
    localparam logic [2:0]       C_OP_OWNER  = 3'd3;
    localparam logic [2:0]       C_OP_INVAL  = 3'd4;
    localparam logic [OID_W:0]   C_CORES     = (OID_W+1)'(CORES);
    localparam logic [SET_W-1:0] C_LAST_SET  = SET_W'(SETS - 1);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_IDLE = 2'd1,
        S_EXEC = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t r_state;
    logic [SET_W-1:0] r_sweep_ctr;

    // Latched request
    logic [2:0]       r_op;
    logic [SET_W-1:0] r_set;
    logic [WAY_W-1:0] r_way;
    logic [OID_W-1:0] r_core;
    logic             r_dirty;

    // Directory storage, one packed set image per entry (not reset; the
    // post-reset sweep clears it)
    logic [WAYS-1:0]       r_mem_valid   [SETS];
    logic [WAYS*CORES-1:0] r_mem_sharers [SETS];
    logic [WAYS-1:0]       r_mem_ov      [SETS];
    logic [WAYS*OID_W-1:0] r_mem_oid     [SETS];
    logic [WAYS-1:0]       r_mem_dirty   [SETS];

    // Current set image
    logic [WAYS-1:0]       w_cur_valid;
    logic [WAYS*CORES-1:0] w_cur_sharers;
    logic [WAYS-1:0]       w_cur_ov;
    logic [WAYS*OID_W-1:0] w_cur_oid;
    logic [WAYS-1:0]       w_cur_dirty;

    // Next set image
    logic [WAYS-1:0]       w_new_valid;
    logic [WAYS*CORES-1:0] w_new_sharers;
    logic [WAYS-1:0]       w_new_ov;
    logic [WAYS*OID_W-1:0] w_new_oid;
    logic [WAYS-1:0]       w_new_dirty;

    // Target-way fields before and after the op
    logic             w_t_valid, w_n_valid;
    logic [CORES-1:0] w_t_sharers, w_n_sharers;
    logic             w_t_ov, w_n_ov;
    logic [OID_W-1:0] w_t_oid, w_n_oid;
    logic             w_t_dirty, w_n_dirty;

    logic [CORES-1:0] w_core_mask;
    logic [CORES-1:0] w_owner_mask;
    logic             w_err;
    logic             w_write;

    assign w_cur_valid   = r_mem_valid[r_set];
    assign w_cur_sharers = r_mem_sharers[r_set];
    assign w_cur_ov      = r_mem_ov[r_set];
    assign w_cur_oid     = r_mem_oid[r_set];
    assign w_cur_dirty   = r_mem_dirty[r_set];

    assign w_t_valid   = w_cur_valid[r_way];
    assign w_t_sharers = w_cur_sharers[r_way*CORES +: CORES];
    assign w_t_ov      = w_cur_ov[r_way];
    assign w_t_oid     = w_cur_oid[r_way*OID_W +: OID_W];
    assign w_t_dirty   = w_cur_dirty[r_way];

    assign w_core_mask  = CORES'(1) << r_core;
    assign w_owner_mask = CORES'(1) << w_t_oid;

    // Illegal ops and out-of-range cores degrade to a LOOKUP
    assign w_err   = (r_op > C_OP_INVAL) || ({1'b0, r_core} >= C_CORES);
    assign w_write = !w_err && (r_op != C_OP_LOOKUP);

    // Per-op update of the target way. Every branch leaves the stored
    // invariants intact: dirty implies owner, owner implies no sharers, and
    // an invalid way is all zeros. The owner id is cleared together with
    // owner_valid so a dropped owner leaves no stale id behind.
    always_comb begin
        w_n_valid   = w_t_valid;
        w_n_sharers = w_t_sharers;
        w_n_ov      = w_t_ov;
        w_n_oid     = w_t_oid;
        w_n_dirty   = w_t_dirty;
        if (w_write) begin
            case (r_op)
                C_OP_ADD: begin
                    w_n_valid = 1'b1;
                    if (w_t_ov) begin
                        // Owner is demoted to a sharer alongside the requester
                        w_n_sharers = w_owner_mask | w_core_mask;
                        w_n_ov      = 1'b0;
                        w_n_oid     = '0;
                        w_n_dirty   = 1'b0;
                    end else begin
                        w_n_sharers = w_t_sharers | w_core_mask;
                    end
                end
                C_OP_REMOVE: begin
                    w_n_sharers = w_t_sharers & ~w_core_mask;
                    if (w_t_ov && (w_t_oid == r_core)) begin
                        w_n_ov    = 1'b0;
                        w_n_oid   = '0;
                        w_n_dirty = 1'b0;
                    end
                end
                C_OP_OWNER: begin
                    w_n_valid   = 1'b1;
                    w_n_ov      = 1'b1;
                    w_n_oid     = r_core;
                    w_n_sharers = '0;
                    w_n_dirty   = r_dirty;
                end
                C_OP_INVAL: begin
                    w_n_valid   = 1'b0;
                    w_n_sharers = '0;
                    w_n_ov      = 1'b0;
                    w_n_oid     = '0;
                    w_n_dirty   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Splice the target way back into the set image; other ways pass through
    always_comb begin
        w_new_valid   = w_cur_valid;
        w_new_sharers = w_cur_sharers;
        w_new_ov      = w_cur_ov;
        w_new_oid     = w_cur_oid;
        w_new_dirty   = w_cur_dirty;
        w_new_valid[r_way]                   = w_n_valid;
        w_new_sharers[r_way*CORES +: CORES]  = w_n_sharers;
        w_new_ov[r_way]                      = w_n_ov;
        w_new_oid[r_way*OID_W +: OID_W]      = w_n_oid;
        w_new_dirty[r_way]                   = w_n_dirty;
    end

    // Storage writes: sweep clears one set per cycle, EXEC writes back
    always_ff @(posedge clk) begin
        if (r_state == S_INIT) begin
            r_mem_valid[r_sweep_ctr]   <= '0;
            r_mem_sharers[r_sweep_ctr] <= '0;
            r_mem_ov[r_sweep_ctr]      <= '0;
            r_mem_oid[r_sweep_ctr]     <= '0;
            r_mem_dirty[r_sweep_ctr]   <= '0;
        end else if ((r_state == S_EXEC) && w_write) begin
            r_mem_valid[r_set]   <= w_new_valid;
            r_mem_sharers[r_set] <= w_new_sharers;
            r_mem_ov[r_set]      <= w_new_ov;
            r_mem_oid[r_set]     <= w_new_oid;
            r_mem_dirty[r_set]   <= w_new_dirty;
        end
    end

    // Control FSM and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= S_INIT;
            r_sweep_ctr       <= '0;
            r_op              <= '0;
            r_set             <= '0;
            r_way             <= '0;
            r_core            <= '0;
            r_dirty           <= 1'b0;
            rsp_hit_o         <= 1'b0;
            rsp_err_o         <= 1'b0;
            rsp_valid_vec_o   <= '0;
            rsp_sharers_o     <= '0;
            rsp_owner_valid_o <= '0;
            rsp_owner_id_o    <= '0;
            rsp_dirty_o       <= '0;
        end else begin
            case (r_state)
                S_INIT: begin
                    r_sweep_ctr <= r_sweep_ctr + 1'b1;
                    if (r_sweep_ctr == C_LAST_SET) begin
                        r_state <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_op    <= req_op_i;
                        r_set   <= req_set_i;
                        r_way   <= req_way_i;
                        r_core  <= req_core_i;
                        r_dirty <= req_dirty_i;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_hit_o         <= w_t_valid;
                    rsp_err_o         <= w_err;
                    rsp_valid_vec_o   <= w_new_valid;
                    rsp_sharers_o     <= w_new_sharers;
                    rsp_owner_valid_o <= w_new_ov;
                    rsp_owner_id_o    <= w_new_oid;
                    rsp_dirty_o       <= w_new_dirty;
                    r_state           <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign init_busy_o = (r_state == S_INIT);
    assign req_ready_o = (r_state == S_IDLE);
    assign rsp_valid_o = (r_state == S_RESP);

endmodule
`default_nettype wire

// File: tb/tb_rv64g_l2_dir_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv64g_l2_dir_ctrl
// Description : Self-checking bench for rv64g_l2_dir_ctrl. Directed vectors
//               with hand-computed set images, plus sequences for the
//               post-reset sweep, response back-pressure and reset mid-op.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv64g_l2_dir_ctrl;

    logic        clk;
    logic        rst_n;
    logic        init_busy_o;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  req_op_i;
    logic [7:0]  req_set_i;
    logic [3:0]  req_way_i;
    logic [1:0]  req_core_i;
    logic        req_dirty_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        rsp_hit_o;
    logic        rsp_err_o;
    logic [15:0] rsp_valid_vec_o;
    logic [63:0] rsp_sharers_o;
    logic [15:0] rsp_owner_valid_o;
    logic [31:0] rsp_owner_id_o;
    logic [15:0] rsp_dirty_o;

    int checks = 0;
    int errors = 0;

    rv64g_l2_dir_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .init_busy_o       (init_busy_o),
        .req_valid_i       (req_valid_i),
        .req_ready_o       (req_ready_o),
        .req_op_i          (req_op_i),
        .req_set_i         (req_set_i),
        .req_way_i         (req_way_i),
        .req_core_i        (req_core_i),
        .req_dirty_i       (req_dirty_i),
        .rsp_valid_o       (rsp_valid_o),
        .rsp_ready_i       (rsp_ready_i),
        .rsp_hit_o         (rsp_hit_o),
        .rsp_err_o         (rsp_err_o),
        .rsp_valid_vec_o   (rsp_valid_vec_o),
        .rsp_sharers_o     (rsp_sharers_o),
        .rsp_owner_valid_o (rsp_owner_valid_o),
        .rsp_owner_id_o    (rsp_owner_id_o),
        .rsp_dirty_o       (rsp_dirty_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  set;
        logic [3:0]  way;
        logic [1:0]  core;
        logic        dirty;
        logic        e_hit;
        logic        e_err;
        logic [15:0] e_vv;
        logic [3:0]  e_sh;
        logic        e_ov;
        logic [1:0]  e_oid;
        logic        e_d;
    } vec_t;

    vec_t vec [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Wait for the sweep to finish; returns number of cycles init_busy_o was seen high
    task automatic wait_sweep(output int n);
        n = 0;
        while (init_busy_o && n < 2000) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    // Drive one request, check the two-cycle accept-to-response latency and
    // leave the response pending
    task automatic issue(input logic [2:0] op, input logic [7:0] set, input logic [3:0] way,
                         input logic [1:0] core, input logic dirty);
        int n;
        n = 0;
        @(negedge clk);
        req_op_i    = op;
        req_set_i   = set;
        req_way_i   = way;
        req_core_i  = core;
        req_dirty_i = dirty;
        req_valid_i = 1'b1;
        while (!req_ready_o && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) chk("req_ready_timeout", 64'(req_ready_o), 64'd1);
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        chk("rsp_valid_in_exec", 64'(rsp_valid_o), 64'd0);
        @(posedge clk);
        #1;
        chk("rsp_valid_after_exec", 64'(rsp_valid_o), 64'd1);
    endtask

    task automatic release_rsp();
        rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready_i = 1'b0;
        chk("rsp_valid_after_hs", 64'(rsp_valid_o), 64'd0);
        chk("req_ready_after_hs", 64'(req_ready_o), 64'd1);
    endtask

    initial begin
        int n;
        int w;

        //         op    set    way  core dirty hit err  vv        sh       ov  oid  d
        vec[0]  = '{3'd0, 8'd0,   4'd0, 2'd0, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vec[1]  = '{3'd1, 8'd5,   4'd3, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0008, 4'b0010, 1'b0, 2'd0, 1'b0};
        vec[2]  = '{3'd1, 8'd5,   4'd3, 2'd2, 1'b0, 1'b1, 1'b0, 16'h0008, 4'b0110, 1'b0, 2'd0, 1'b0};
        vec[3]  = '{3'd3, 8'd5,   4'd3, 2'd3, 1'b1, 1'b1, 1'b0, 16'h0008, 4'b0000, 1'b1, 2'd3, 1'b1};
        vec[4]  = '{3'd1, 8'd5,   4'd3, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0008, 4'b1001, 1'b0, 2'd0, 1'b0};
        vec[5]  = '{3'd3, 8'd5,   4'd3, 2'd2, 1'b1, 1'b1, 1'b0, 16'h0008, 4'b0000, 1'b1, 2'd2, 1'b1};
        vec[6]  = '{3'd2, 8'd5,   4'd3, 2'd2, 1'b0, 1'b1, 1'b0, 16'h0008, 4'b0000, 1'b0, 2'd0, 1'b0};
        vec[7]  = '{3'd4, 8'd5,   4'd3, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vec[8]  = '{3'd6, 8'd5,   4'd3, 2'd1, 1'b0, 1'b0, 1'b1, 16'h0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vec[9]  = '{3'd3, 8'd5,   4'd7, 2'd1, 1'b0, 1'b0, 1'b0, 16'h0080, 4'b0000, 1'b1, 2'd1, 1'b0};
        vec[10] = '{3'd1, 8'd5,   4'd3, 2'd3, 1'b0, 1'b0, 1'b0, 16'h0088, 4'b1000, 1'b0, 2'd0, 1'b0};
        vec[11] = '{3'd2, 8'd5,   4'd7, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0088, 4'b0000, 1'b1, 2'd1, 1'b0};
        vec[12] = '{3'd1, 8'd5,   4'd7, 2'd1, 1'b0, 1'b1, 1'b0, 16'h0088, 4'b0010, 1'b0, 2'd0, 1'b0};
        vec[13] = '{3'd2, 8'd200, 4'd15, 2'd2, 1'b0, 1'b0, 1'b0, 16'h0000, 4'b0000, 1'b0, 2'd0, 1'b0};
        vec[14] = '{3'd7, 8'd5,   4'd7, 2'd2, 1'b1, 1'b1, 1'b1, 16'h0088, 4'b0010, 1'b0, 2'd0, 1'b0};
        vec[15] = '{3'd0, 8'd5,   4'd3, 2'd0, 1'b0, 1'b1, 1'b0, 16'h0088, 4'b1000, 1'b0, 2'd0, 1'b0};

        rst_n       = 1'b0;
        req_valid_i = 1'b0;
        req_op_i    = '0;
        req_set_i   = '0;
        req_way_i   = '0;
        req_core_i  = '0;
        req_dirty_i = 1'b0;
        rsp_ready_i = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_init_busy", 64'(init_busy_o), 64'd1);
        chk("reset_req_ready", 64'(req_ready_o), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("reset_rsp_image", {rsp_sharers_o[31:0], rsp_valid_vec_o, rsp_dirty_o}, 64'd0);

        @(negedge clk);
        rst_n = 1'b1;
        wait_sweep(n);
        chk("sweep_cycles", 64'(n), 64'd256);
        chk("idle_req_ready", 64'(req_ready_o), 64'd1);

        for (int i = 0; i < 16; i++) begin
            issue(vec[i].op, vec[i].set, vec[i].way, vec[i].core, vec[i].dirty);
            w = int'(vec[i].way);
            chk($sformatf("v%0d_hit", i), 64'(rsp_hit_o), 64'(vec[i].e_hit));
            chk($sformatf("v%0d_err", i), 64'(rsp_err_o), 64'(vec[i].e_err));
            chk($sformatf("v%0d_valid_vec", i), 64'(rsp_valid_vec_o), 64'(vec[i].e_vv));
            chk($sformatf("v%0d_sharers", i), 64'(rsp_sharers_o[w*4 +: 4]), 64'(vec[i].e_sh));
            chk($sformatf("v%0d_owner_valid", i), 64'(rsp_owner_valid_o[w]), 64'(vec[i].e_ov));
            if (vec[i].e_ov)
                chk($sformatf("v%0d_owner_id", i), 64'(rsp_owner_id_o[w*2 +: 2]), 64'(vec[i].e_oid));
            chk($sformatf("v%0d_dirty", i), 64'(rsp_dirty_o[w]), 64'(vec[i].e_d));
            release_rsp();
        end

        // Back-pressure: response held stable and no new request accepted
        issue(3'd3, 8'd9, 4'd1, 2'd1, 1'b1);
        req_valid_i = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk("stall_rsp_valid", 64'(rsp_valid_o), 64'd1);
            chk("stall_req_ready", 64'(req_ready_o), 64'd0);
            chk("stall_valid_vec", 64'(rsp_valid_vec_o), 64'h0002);
            chk("stall_sharers", rsp_sharers_o, 64'd0);
            chk("stall_owner", {rsp_owner_valid_o, rsp_owner_id_o, rsp_dirty_o}, {16'h0002, 32'h4, 16'h0002});
            chk("stall_hit_err", {62'd0, rsp_hit_o, rsp_err_o}, 64'd0);
        end
        req_valid_i = 1'b0;
        release_rsp();

        // Reset while an op is in EXEC
        @(negedge clk);
        req_op_i    = 3'd3;
        req_set_i   = 8'd5;
        req_way_i   = 4'd2;
        req_core_i  = 2'd0;
        req_dirty_i = 1'b1;
        req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midop_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("midop_init_busy", 64'(init_busy_o), 64'd1);
        chk("midop_req_ready", 64'(req_ready_o), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_sweep(n);
        chk("resweep_cycles", 64'(n), 64'd256);

        issue(3'd0, 8'd5, 4'd3, 2'd0, 1'b0);
        chk("post_reset_hit", 64'(rsp_hit_o), 64'd0);
        chk("post_reset_valid_vec", 64'(rsp_valid_vec_o), 64'd0);
        chk("post_reset_sharers", rsp_sharers_o, 64'd0);
        release_rsp();

        issue(3'd0, 8'd9, 4'd1, 2'd0, 1'b0);
        chk("post_reset_set9", {rsp_valid_vec_o, rsp_owner_valid_o, rsp_dirty_o}, 64'd0);
        release_rsp();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit so the bench always terminates
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
